count_sequencer: RTL and testbench

- Run/pause/lap/target controller for the team's 16-bit enable-driven up-counter, as used for the HEX stopwatch display.
- Converts pushbutton command levels into rising-edge commands and divides the board clock into one-cycle count-enable ticks.
- Drives the counter's enable and a clear request, and selects whether the hex display path shows the live count or a frozen lap value.
- Sits between KEY/SW inputs and the counter plus hex decoders, sharing clk with the counter.

---
 rtl/count_sequencer.sv | 142 ++++++++++++++
 tb/tb_count_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// Run/pause/lap/target controller for the stopwatch up-counter.
// Edge-detects button levels, prescales clk into count ticks, drives counter enable/clear and display mux.
module count_sequencer #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned PRESCALE   = 4,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start_btn,
    input  logic             stop_btn,
    input  logic             lap_btn,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] count_value,
    output logic             cnt_enable,
    output logic             cnt_clear,
    output logic [WIDTH-1:0] display_value,
    output logic             done,
    output logic [2:0]       state_code
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_LAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [PRESCALE_W-1:0] PRESC_MAX = PRESCALE_W'(PRESCALE - 1);

    state_t                r_state;
    logic [PRESCALE_W-1:0] r_presc;
    logic [WIDTH-1:0]      r_lap;
    logic                  r_start_d;
    logic                  r_stop_d;
    logic                  r_lap_d;
    logic                  r_clear;
    logic                  r_done;

    logic w_stop;
    logic w_start;
    logic w_lap;
    logic w_active;
    logic w_hit;
    logic w_tick;

    // One command per clock: stop masks start, both mask lap.
    assign w_stop   = stop_btn & ~r_stop_d;
    assign w_start  = start_btn & ~r_start_d & ~w_stop;
    assign w_lap    = lap_btn & ~r_lap_d & ~w_stop & ~w_start;

    assign w_active = (r_state == S_RUN) || (r_state == S_LAP);
    assign w_hit    = (target != '0) && (count_value == target);
    assign w_tick   = w_active && (r_presc == PRESC_MAX);

    assign cnt_enable    = w_tick & ~w_hit & ~r_clear;
    assign cnt_clear     = r_clear;
    assign done          = r_done;
    assign state_code    = 3'(r_state);
    assign display_value = (r_state == S_LAP) ? r_lap : count_value;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_lap     <= '0;
            r_start_d <= 1'b0;
            r_stop_d  <= 1'b0;
            r_lap_d   <= 1'b0;
            r_clear   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_start_d <= start_btn;
            r_stop_d  <= stop_btn;
            r_lap_d   <= lap_btn;
            r_clear   <= 1'b0;

            // Prescaler runs in RUN/LAP, freezes in PAUSE, sits at zero otherwise.
            case (r_state)
                S_RUN, S_LAP: r_presc <= (r_presc == PRESC_MAX) ? '0 : r_presc + PRESCALE_W'(1);
                S_PAUSE:      r_presc <= r_presc;
                default:      r_presc <= '0;
            endcase

            // A clear already in flight zeroes the counter, so back-to-back requests collapse to one pulse.
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_RUN;
                        r_clear <= ~r_clear;
                    end
                end
                S_RUN: begin
                    if (w_hit) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else if (w_stop) begin
                        r_state <= S_PAUSE;
                    end else if (w_lap) begin
                        r_state <= S_LAP;
                        r_lap   <= count_value;
                    end
                end
                S_LAP: begin
                    if (w_hit) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else if (w_stop) begin
                        r_state <= S_PAUSE;
                    end else if (w_lap) begin
                        r_state <= S_RUN;
                    end
                end
                S_PAUSE: begin
                    if (w_stop) begin
                        r_state <= S_IDLE;
                        r_clear <= ~r_clear;
                    end else if (w_start) begin
                        r_state <= S_RUN;
                    end
                end
                S_DONE: begin
                    if (w_stop) begin
                        r_state <= S_IDLE;
                        r_clear <= ~r_clear;
                        r_done  <= 1'b0;
                    end else if (w_start) begin
                        r_state <= S_RUN;
                        r_clear <= ~r_clear;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with a behavioural 16-bit counter and a tick scoreboard.
module tb_count_sequencer;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned PRESCALE = 4;

    localparam int B_START = 0;
    localparam int B_STOP  = 1;
    localparam int B_LAP   = 2;
    localparam int B_BOTH  = 3;

    logic             clk = 1'b0;
    logic             clear = 1'b1;
    logic             start_btn = 1'b0;
    logic             stop_btn = 1'b0;
    logic             lap_btn = 1'b0;
    logic [WIDTH-1:0] target = '0;
    logic [WIDTH-1:0] cnt;
    logic             cnt_enable;
    logic             cnt_clear;
    logic [WIDTH-1:0] display_value;
    logic             done;
    logic [2:0]       state_code;

    int checks = 0;
    int failures = 0;
    logic [WIDTH-1:0] exp_q[$];

    count_sequencer #(.WIDTH(WIDTH), .PRESCALE(PRESCALE), .PRESCALE_W(16)) dut (
        .clk           (clk),
        .clear         (clear),
        .start_btn     (start_btn),
        .stop_btn      (stop_btn),
        .lap_btn       (lap_btn),
        .target        (target),
        .count_value   (cnt),
        .cnt_enable    (cnt_enable),
        .cnt_clear     (cnt_clear),
        .display_value (display_value),
        .done          (done),
        .state_code    (state_code)
    );

    always #5 clk = ~clk;

    // Behavioural model of the enable-driven counter sharing clk.
    always @(posedge clk or posedge clear) begin
        if (clear)           cnt <= '0;
        else if (cnt_clear)  cnt <= '0;
        else if (cnt_enable) cnt <= 16'(cnt + 16'd1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int which);
        if (which == B_START || which == B_BOTH) start_btn = 1'b1;
        if (which == B_STOP  || which == B_BOTH) stop_btn  = 1'b1;
        if (which == B_LAP)                      lap_btn   = 1'b1;
        @(posedge clk);
        #1;
        if (which == B_START || which == B_BOTH) start_btn = 1'b0;
        if (which == B_STOP  || which == B_BOTH) stop_btn  = 1'b0;
        if (which == B_LAP)                      lap_btn   = 1'b0;
    endtask

    task automatic push_ticks(input int from, input int to);
        for (int v = from; v <= to; v++) exp_q.push_back(16'(v));
    endtask

    // Every observed tick must match the next expected count value.
    always @(negedge clk) begin
        if (cnt_enable === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_tick: observed tick at count=%0h expected no tick", cnt);
            end
            if (exp_q.size() > 0) check("tick_count", 32'(cnt), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        step(2);
        check("rst_state", 32'(state_code), 0);
        check("rst_enable", 32'(cnt_enable), 0);
        check("rst_clear", 32'(cnt_clear), 0);
        check("rst_done", 32'(done), 0);
        check("rst_display", 32'(display_value), 32'(cnt));
        clear = 1'b0;
        step(1);

        // Fresh start, free-run
        press(B_START);
        check("start_state", 32'(state_code), 1);
        check("start_clear", 32'(cnt_clear), 1);
        push_ticks(0, 2);
        step(1);
        check("start_clear_once", 32'(cnt_clear), 0);
        step(11);
        check("count_after_12", 32'(cnt), 3);
        check("q_empty_1", 32'(exp_q.size()), 0);

        // Pause keeps count and prescaler phase
        push_ticks(3, 4);
        step(8);
        check("count_5", 32'(cnt), 5);
        step(2);
        press(B_STOP);
        check("pause_state", 32'(state_code), 2);
        step(20);
        check("pause_hold_state", 32'(state_code), 2);
        check("pause_hold_count", 32'(cnt), 5);
        push_ticks(5, 5);
        press(B_START);
        check("resume_state", 32'(state_code), 1);
        check("resume_no_clear", 32'(cnt_clear), 0);
        check("resume_phase_tick", 32'(cnt_enable), 1);
        press(B_STOP);
        check("pause2_state", 32'(state_code), 2);
        step(1);
        press(B_STOP);
        check("idle_state", 32'(state_code), 0);
        check("idle_clear", 32'(cnt_clear), 1);
        step(1);
        check("idle_clear_once", 32'(cnt_clear), 0);
        check("idle_count_zero", 32'(cnt), 0);
        step(3);
        check("idle_clear_quiet", 32'(cnt_clear), 0);
        check("q_empty_2", 32'(exp_q.size()), 0);

        // Lap freeze and release
        press(B_START);
        push_ticks(0, 6);
        step(28);
        check("count_7", 32'(cnt), 7);
        press(B_LAP);
        check("lap_state", 32'(state_code), 3);
        check("lap_display", 32'(display_value), 7);
        push_ticks(7, 9);
        step(11);
        check("lap_count_10", 32'(cnt), 10);
        check("lap_display_frozen", 32'(display_value), 7);
        press(B_LAP);
        check("unlap_state", 32'(state_code), 1);
        check("unlap_display", 32'(display_value), 10);
        press(B_STOP);
        step(1);
        press(B_STOP);
        step(1);
        check("q_empty_3", 32'(exp_q.size()), 0);

        // Target stop at 6
        target = 16'd6;
        press(B_START);
        push_ticks(0, 5);
        step(24);
        check("tgt_count", 32'(cnt), 6);
        check("tgt_enable_off", 32'(cnt_enable), 0);
        check("tgt_not_done_yet", 32'(done), 0);
        step(1);
        check("tgt_done", 32'(done), 1);
        check("tgt_state", 32'(state_code), 4);
        step(10);
        check("tgt_no_pass", 32'(cnt), 6);
        check("tgt_state_hold", 32'(state_code), 4);
        check("q_empty_4", 32'(exp_q.size()), 0);
        press(B_START);
        check("restart_clear", 32'(cnt_clear), 1);
        check("restart_state", 32'(state_code), 1);
        check("restart_done_low", 32'(done), 0);
        step(1);
        check("restart_count", 32'(cnt), 0);
        press(B_STOP);
        step(1);
        press(B_STOP);
        step(1);

        // Same-cycle command priority and target override
        target = '0;
        press(B_START);
        step(1);
        press(B_BOTH);
        check("stop_wins", 32'(state_code), 2);
        step(1);
        press(B_STOP);
        step(1);
        check("prio_idle", 32'(state_code), 0);
        target = 16'd2;
        press(B_START);
        push_ticks(0, 1);
        step(8);
        check("ovr_count", 32'(cnt), 2);
        press(B_STOP);
        check("ovr_state", 32'(state_code), 4);
        check("ovr_done", 32'(done), 1);
        step(1);
        press(B_STOP);
        check("done_stop_state", 32'(state_code), 0);
        check("done_stop_clear", 32'(cnt_clear), 1);
        step(1);
        check("q_empty_5", 32'(exp_q.size()), 0);

        // Asynchronous clear mid-run, start held through release
        target = '0;
        press(B_START);
        step(3);
        check("pre_rst_tick", 32'(cnt_enable), 1);
        #2;
        clear = 1'b1;
        start_btn = 1'b1;
        #1;
        check("arst_state", 32'(state_code), 0);
        check("arst_enable", 32'(cnt_enable), 0);
        check("arst_done", 32'(done), 0);
        step(2);
        clear = 1'b0;
        step(1);
        check("held_start_state", 32'(state_code), 1);
        check("held_start_clear", 32'(cnt_clear), 1);
        step(1);
        check("held_start_once", 32'(cnt_clear), 0);
        press(B_STOP);
        step(5);
        check("held_no_restart", 32'(state_code), 2);
        check("held_clear_quiet", 32'(cnt_clear), 0);
        start_btn = 1'b0;
        step(1);
        check("q_empty_6", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
